// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipe: load-use stall, jump squash,
// memory-wait freeze with timeout flag, and saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_memtoreg,
    input  logic             ex_regwr,
    input  logic             ex_jump_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    state_e          state_q;
    state_e          state_d;
    logic [TO_W-1:0] to_q;
    logic [TO_W-1:0] to_d;
    logic            mem_err_q;
    logic            mem_err_d;

    logic freeze;
    logic lu;
    logic in_run;
    logic jump_flush;
    logic any_hold;

    assign freeze = mem_req & ~mem_ready;
    assign lu     = ex_memtoreg & ex_regwr & (ex_rt != REG_ZERO) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    // The unused encoding 3 behaves like RUN until the next edge recovers it.
    assign in_run = (state_q != LU_BUBBLE) && (state_q != MEM_WAIT);

    always_comb begin
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_hold  = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        jump_flush = 1'b0;
        if (!rst_n) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
        end else if (ex_jump_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            jump_flush = 1'b1;
        end else if (lu && in_run) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = RUN;
        if (freeze) begin
            state_d = MEM_WAIT;
        end else if (in_run && !ex_jump_taken && lu) begin
            state_d = LU_BUBBLE;
        end
    end

    // The wait counter tracks consecutive frozen edges, including the one entering MEM_WAIT.
    always_comb begin
        to_d = '0;
        if (freeze) begin
            to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
        end
        mem_err_d = mem_err_q | (to_d == TO_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            to_q      <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign any_hold = pc_hold | ifid_hold | idex_hold | exmem_hold;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (any_hold),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (jump_flush),
        .cnt   (flush_cnt)
    );

    assign mem_err = mem_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rt;
    logic       ex_memtoreg;
    logic       ex_regwr;
    logic       ex_jump_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       cnt_clr;
    logic       pc_hold;
    logic       ifid_hold;
    logic       ifid_flush;
    logic       idex_hold;
    logic       idex_flush;
    logic       exmem_hold;
    logic       mem_err;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_rt         (ex_rt),
        .ex_memtoreg   (ex_memtoreg),
        .ex_regwr      (ex_regwr),
        .ex_jump_taken (ex_jump_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .cnt_clr       (cnt_clr),
        .pc_hold       (pc_hold),
        .ifid_hold     (ifid_hold),
        .ifid_flush    (ifid_flush),
        .idex_hold     (idex_hold),
        .idex_flush    (idex_flush),
        .exmem_hold    (exmem_hold),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0;
        ex_memtoreg = 0; ex_regwr = 0; ex_jump_taken = 0;
        mem_req = 0; mem_ready = 0; cnt_clr = 0;
    endtask

    task automatic holds4(input string tag, input logic exp);
        chk({tag, "_pc_hold"}, pc_hold, exp);
        chk({tag, "_ifid_hold"}, ifid_hold, exp);
        chk({tag, "_idex_hold"}, idex_hold, exp);
        chk({tag, "_exmem_hold"}, exmem_hold, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        // Reset state: pipe drains to bubbles
        settle();
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_flush", idex_flush, 1);
        holds4("rst", 0);
        chk("rst_state", state, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_mem_err", mem_err, 0);
        // Reset overrides a pending freeze
        mem_req = 1; settle();
        chk("rst_freeze_pc_hold", pc_hold, 0);
        chk("rst_freeze_ifid_flush", ifid_flush, 1);
        mem_req = 0;
        rst_n = 1'b1;
        tick();

        // 1. Load-use: one bubble
        ex_memtoreg = 1; ex_regwr = 1; ex_rt = 8; id_rs = 8; settle();
        chk("lu_pc_hold", pc_hold, 1);
        chk("lu_ifid_hold", ifid_hold, 1);
        chk("lu_idex_flush", idex_flush, 1);
        chk("lu_ifid_flush", ifid_flush, 0);
        chk("lu_exmem_hold", exmem_hold, 0);
        tick();
        chk("lu_state_bubble", state, 1);
        chk("lu_bubble_pc_hold", pc_hold, 0);
        chk("lu_bubble_idex_flush", idex_flush, 0);
        chk("lu_stall_cnt1", stall_cnt, 1);
        tick();
        chk("lu_state_back", state, 0);
        chk("lu_stall_cnt2", stall_cnt, 1);
        clear_inputs(); settle();

        // 2. No false hazards
        ex_memtoreg = 1; ex_regwr = 1; ex_rt = 0; id_rs = 0; settle();
        chk("r0_pc_hold", pc_hold, 0);
        chk("r0_idex_flush", idex_flush, 0);
        tick();
        chk("r0_state", state, 0);
        ex_rt = 9; id_rt = 9; id_rs = 1; id_uses_rt = 0; settle();
        chk("rt_unused_pc_hold", pc_hold, 0);
        tick();
        chk("rt_unused_state", state, 0);
        id_uses_rt = 1; settle();
        chk("rt_used_pc_hold", pc_hold, 1);
        ex_regwr = 0; settle();
        chk("no_regwr_pc_hold", pc_hold, 0);
        clear_inputs();
        cnt_clr = 1; tick(); cnt_clr = 0;

        // 3. Jump beats load-use
        ex_memtoreg = 1; ex_regwr = 1; ex_rt = 8; id_rs = 8; ex_jump_taken = 1; settle();
        chk("jmp_ifid_flush", ifid_flush, 1);
        chk("jmp_idex_flush", idex_flush, 1);
        chk("jmp_pc_hold", pc_hold, 0);
        chk("jmp_ifid_hold", ifid_hold, 0);
        tick();
        chk("jmp_state", state, 0);
        chk("jmp_flush_cnt", flush_cnt, 1);
        chk("jmp_stall_cnt", stall_cnt, 0);
        clear_inputs();
        cnt_clr = 1; tick(); cnt_clr = 0;

        // 4. Memory wait, jump ignored while frozen
        mem_req = 1; mem_ready = 0; ex_jump_taken = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            holds4("mw", 1);
            chk("mw_ifid_flush", ifid_flush, 0);
            chk("mw_idex_flush", idex_flush, 0);
            tick();
            chk("mw_state", state, 2);
        end
        mem_ready = 1; ex_jump_taken = 0; settle();
        holds4("mw_ready", 0);
        tick();
        chk("mw_ready_state", state, 0);
        chk("mw_stall_cnt", stall_cnt, 3);
        chk("mw_flush_cnt", flush_cnt, 0);
        chk("mw_mem_err", mem_err, 0);

        // 5. Timeout
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_before", mem_err, 0);
        end
        tick();
        chk("to_after4", mem_err, 1);
        tick(); tick();
        chk("to_after6", mem_err, 1);
        chk("to_state", state, 2);
        mem_ready = 1; tick();
        chk("to_ready_state", state, 0);
        chk("to_sticky1", mem_err, 1);
        mem_req = 0; mem_ready = 0; tick();
        chk("to_sticky2", mem_err, 1);
        rst_n = 0; tick(); rst_n = 1;
        chk("to_rst_clear", mem_err, 0);

        // 6. Counter saturation, clear priority, reset mid-stall
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", stall_cnt, 15);
        cnt_clr = 1; tick(); cnt_clr = 0;
        chk("clr_prio_stall_cnt", stall_cnt, 0);
        tick();
        chk("post_clr_stall_cnt", stall_cnt, 1);
        mem_req = 0; ex_jump_taken = 1; tick(); ex_jump_taken = 0;
        chk("pre_rst_flush_cnt", flush_cnt, 1);
        mem_req = 1; tick(); tick();
        chk("pre_rst_state", state, 2);
        chk("pre_rst_stall_cnt", stall_cnt, 3);
        rst_n = 0; settle();
        chk("midrst_pc_hold", pc_hold, 0);
        chk("midrst_ifid_flush", ifid_flush, 1);
        tick();
        chk("midrst_state", state, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_flush_cnt", flush_cnt, 0);
        chk("midrst_mem_err", mem_err, 0);
        rst_n = 1; clear_inputs(); tick();
        chk("final_state", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives hold and flush controls into the PC, IF/ID, ID/EX and EX/MEM stage registers.
- Detects load-use hazards, squashes wrong-path instructions when a jump or branch resolves taken in EX, and freezes the pipe while data memory is not ready.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.
- MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles after which mem_err is set.
- TO_W, 8, width of the internal timeout counter. It must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock. Controller state updates on posedge. Stage registers sample on negedge.
- rst_n  in  1  synchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- ex_rt  in  5  destination rt of the instruction in EX.
- ex_memtoreg  in  1  the EX instruction is a load.
- ex_regwr  in  1  the EX instruction writes the register file.
- ex_jump_taken  in  1  jump, jr, jal or branch resolved taken in EX.
- mem_req  in  1  the MEM stage is accessing data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- cnt_clr  in  1  clears both performance counters.
- pc_hold  out  1  hold the PC.
- ifid_hold  out  1  hold the IF/ID register.
- ifid_flush  out  1  load a bubble into IF/ID.
- idex_hold  out  1  hold the ID/EX register.
- idex_flush  out  1  load a bubble into ID/EX.
- exmem_hold  out  1  hold the EX/MEM register.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  number of cycles with any hold asserted.
- flush_cnt  out  CNT_W  number of cycles with a jump flush.
- state  out  2  current FSM state, for debug.

Behaviour:
- Hold and flush outputs are combinational from the current inputs and state. They settle before the negedge at which the stage registers sample.
- State, counters and mem_err update only on posedge clk.
- Reset (rst_n=0 at posedge):
  - state goes to RUN.
  - stall_cnt and flush_cnt go to 0. mem_err goes to 0. The timeout counter goes to 0.
  - While rst_n=0, ifid_flush=idex_flush=1 and all holds are 0, so the pipe drains to bubbles.
  - Reset mid-MEM_WAIT abandons the wait immediately.
- FSM states: RUN=0, LU_BUBBLE=1, MEM_WAIT=2. Encoding 3 is illegal and recovers to RUN on the next posedge with RUN outputs.
- Signal definitions:
  - freeze = mem_req & !mem_ready.
  - lu = ex_memtoreg & ex_regwr & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Output priority, highest first:
  1. freeze: pc_hold=ifid_hold=idex_hold=exmem_hold=1. Both flushes are 0 and ex_jump_taken is ignored. EX is held, so the jump re-presents after the freeze.
  2. ex_jump_taken: ifid_flush=idex_flush=1, all holds 0.
  3. lu, in RUN only: pc_hold=ifid_hold=1, idex_flush=1, so exactly one bubble is inserted.
  4. Otherwise all outputs are 0.
- Transitions:
  - Any state with freeze goes to MEM_WAIT.
  - RUN with lu, and without freeze or jump, goes to LU_BUBBLE.
  - LU_BUBBLE goes to RUN. lu is suppressed in this state, which guarantees a single-cycle stall.
  - MEM_WAIT with mem_ready=1 goes to RUN. Holds drop in the same cycle mem_ready rises.
- Timeout:
  - The counter increments each posedge spent in MEM_WAIT with freeze, saturating at MEM_TIMEOUT. It clears on leaving MEM_WAIT.
  - When it reaches MEM_TIMEOUT, mem_err is set and stays set until reset. The pipe keeps waiting.
- Performance counters:
  - stall_cnt increments on each posedge where any hold is asserted.
  - flush_cnt increments on each posedge where a jump flush is asserted.
  - Both saturate at all-ones and do not wrap.
  - cnt_clr takes priority over increment in the same cycle.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, LU_BUBBLE, MEM_WAIT);
  - the register-number width constant (5);
  - the constant REG_ZERO=0.
- One natural sub-module, sat_counter (parameter W; inputs inc and clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
1. Load-use: ex_memtoreg=1, ex_regwr=1, ex_rt=8, id_rs=8, for 2 cycles -> first cycle pc_hold=ifid_hold=idex_flush=1; second cycle (LU_BUBBLE) all 0; stall_cnt=1.
2. No false hazard: ex_rt=0 with id_rs=0, or ex_rt=9 with id_rt=9 and id_uses_rt=0 -> no stall; state stays RUN.
3. Jump vs load-use in the same cycle: ex_jump_taken=1 and lu=1 -> ifid_flush=idex_flush=1, pc_hold=0, next state RUN; flush_cnt=1.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all four holds high for 3 cycles and low in the ready cycle; state goes 2,2,2,0; stall_cnt=3.
5. Timeout: MEM_TIMEOUT=4, mem_ready=0 for 6 cycles -> mem_err rises after the 4th posedge, stays 1 after mem_ready=1, and clears only on rst_n=0.
6. Counters: preload stall_cnt near the top (CNT_W=4), drive 20 hold cycles -> saturates at 15; cnt_clr together with a hold in the same cycle -> 0; reset mid-stall -> both counters 0 and state RUN.
